// File: rtl/cordic_vector_pkg.sv
// Shared constants and types for the vectoring-mode CORDIC (phase/magnitude).
package cordic_vector_pkg;

  localparam int WIDTH = 20;
  localparam int ITERS = 16;
  localparam int GUARD = 2;
  localparam int DW    = WIDTH + GUARD;
  localparam int CNT_W = 4;

  // Binary angle: 2^WIDTH counts per full turn
  localparam logic [WIDTH-1:0] PI      = 20'h80000;
  localparam logic [WIDTH-1:0] HALF_PI = 20'h40000;

  // Uncompensated gain of the micro-rotation chain
  localparam real K = 1.646760;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    ITER,
    FIN
  } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent table atan(2^-i) in binary-angle units; same contents as the sine path.
module cordic_atan_rom
  import cordic_vector_pkg::*;
(
  input  logic [CNT_W-1:0] addr,
  output logic [WIDTH-1:0] atan
);

  always_comb begin
    atan = '0;
    case (addr)
      4'd0:  atan = 20'h20000;
      4'd1:  atan = 20'h12E40;
      4'd2:  atan = 20'h09FB4;
      4'd3:  atan = 20'h05111;
      4'd4:  atan = 20'h028B1;
      4'd5:  atan = 20'h0145D;
      4'd6:  atan = 20'h00A2F;
      4'd7:  atan = 20'h00518;
      4'd8:  atan = 20'h0028C;
      4'd9:  atan = 20'h00146;
      4'd10: atan = 20'h000A3;
      4'd11: atan = 20'h00051;
      4'd12: atan = 20'h00029;
      4'd13: atan = 20'h00014;
      4'd14: atan = 20'h0000A;
      4'd15: atan = 20'h00005;
      default: atan = '0;
    endcase
  end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring CORDIC: drives Y to zero, accumulating atan2(y,x) in Z and K*|v| in X.
module cordic_vector
  import cordic_vector_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] angle_out,
  output logic [DW-1:0]    mag_out
);

  state_t state, state_next;

  logic signed [DW-1:0] x_reg, y_reg;
  logic signed [DW-1:0] x_shift, y_shift;
  logic [WIDTH-1:0]     z_reg;
  logic [WIDTH-1:0]     atan;
  logic [CNT_W-1:0]     iter;
  logic                 zero_flag;
  logic                 last_iter;

  cordic_atan_rom u_rom (
    .addr (iter),
    .atan (atan)
  );

  assign x_shift   = x_reg >>> iter;
  assign y_shift   = y_reg >>> iter;
  assign last_iter = (iter == CNT_W'(ITERS - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PRE;
      PRE:     state_next = ITER;
      ITER:    if (last_iter) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Left half-plane vectors are mirrored through the origin first so the
  // iterations only ever need to cover (-pi/2, pi/2); Z starts at pi to undo it.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      iter      <= '0;
      zero_flag <= 1'b0;
      done      <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_reg <= {{GUARD{x_in[WIDTH-1]}}, x_in};
            y_reg <= {{GUARD{y_in[WIDTH-1]}}, y_in};
          end
        end
        PRE: begin
          iter      <= '0;
          zero_flag <= (x_reg == '0) && (y_reg == '0);
          if (x_reg[DW-1]) begin
            x_reg <= -x_reg;
            y_reg <= -y_reg;
            z_reg <= PI;
          end else begin
            z_reg <= '0;
          end
        end
        ITER: begin
          if (!y_reg[DW-1]) begin
            x_reg <= x_reg + y_shift;
            y_reg <= y_reg - x_shift;
            z_reg <= z_reg + atan;
          end else begin
            x_reg <= x_reg - y_shift;
            y_reg <= y_reg + x_shift;
            z_reg <= z_reg - atan;
          end
          iter <= iter + 1'b1;
        end
        FIN: begin
          angle_out <= zero_flag ? '0 : z_reg;
          mag_out   <= zero_flag ? '0 : x_reg;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// Directed bench for cordic_vector: real-arithmetic atan2/magnitude model plus literal checks.
module tb_cordic_vector;
  import cordic_vector_pkg::*;

  localparam real TWO_PI_R = 6.283185307179586;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] x_in = '0;
  logic [WIDTH-1:0] y_in = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] angle_out;
  logic [DW-1:0]    mag_out;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_vector dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .angle_out (angle_out),
    .mag_out   (mag_out)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input bit ok,
                              input longint actual, input longint required);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
    end
  endtask

  function automatic bit near(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] want,
                              input int tol);
    logic signed [WIDTH-1:0] d;
    d = a - want;
    return (d <= tol) && (d >= -tol);
  endfunction

  function automatic real angle_err(input logic [WIDTH-1:0] a, input real want);
    real d;
    d = real'(a) - want;
    while (d >= 524288.0)  d = d - 1048576.0;
    while (d < -524288.0)  d = d + 1048576.0;
    return (d < 0.0) ? -d : d;
  endfunction

  // Behavioural model: one conversion in flight, result due ITERS+2 edges after acceptance
  bit  m_valid = 1'b0;
  bit  m_busy  = 1'b0;
  bit  m_done  = 1'b0;
  bit  m_clear = 1'b1;
  bit  m_zero  = 1'b0;
  int  m_cnt   = 0;
  real m_angle = 0.0;
  real m_mag   = 0.0;

  always @(posedge clk) begin
    real rx, ry;
    m_done = 1'b0;
    if (reset) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_cnt   = 0;
      m_clear = 1'b1;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy  = 1'b0;
        m_done  = 1'b1;
        m_clear = 1'b0;
      end
    end else if (start) begin
      m_busy  = 1'b1;
      m_cnt   = ITERS + 2;
      rx      = real'($signed(x_in));
      ry      = real'($signed(y_in));
      m_zero  = (x_in == '0) && (y_in == '0);
      m_angle = m_zero ? 0.0 : $atan2(ry, rx) * 1048576.0 / TWO_PI_R;
      if (m_angle < 0.0) m_angle = m_angle + 1048576.0;
      m_mag   = K * $sqrt(rx * rx + ry * ry);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check_output("busy", busy === m_busy, busy, m_busy);
      check_output("done", done === m_done, done, m_done);
      if (m_done) begin
        if (m_zero) begin
          check_output("zero_angle", angle_out === '0, angle_out, 0);
          check_output("zero_mag", mag_out === '0, mag_out, 0);
        end else begin
          check_output("model_angle", angle_err(angle_out, m_angle) <= 4.0,
                       angle_out, longint'(m_angle));
          check_output("model_mag",
                       ((real'(mag_out) - m_mag) <= 0.0005 * m_mag + 2.0) &&
                       ((m_mag - real'(mag_out)) <= 0.0005 * m_mag + 2.0),
                       mag_out, longint'(m_mag));
        end
      end else if (m_clear) begin
        check_output("cleared_angle", angle_out === '0, angle_out, 0);
        check_output("cleared_mag", mag_out === '0, mag_out, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issues one request and waits (bounded) for its done pulse
  task automatic apply_stimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int lat;
    x_in  = x;
    y_in  = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    check_output("latency", lat == ITERS + 2, lat, ITERS + 2);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_output("reset_busy", busy === 1'b0, busy, 0);
    check_output("reset_mag", mag_out === '0, mag_out, 0);

    // Truncating shifts bias X upward by a few LSB; 0x1A595 is the exact walk-through value
    apply_stimulus(20'h10000, 20'h00000);
    check_output("x_axis_angle", near(angle_out, 20'h00000, 4), angle_out, 0);
    check_output("x_axis_mag", (mag_out >= 22'h1A58E) && (mag_out <= 22'h1A596),
                 mag_out, 22'h1A592);

    apply_stimulus(20'h10000, 20'h10000);
    check_output("diag_angle", near(angle_out, 20'h20000, 4), angle_out, 20'h20000);
    check_output("diag_mag", (mag_out >= 22'h2542E) && (mag_out <= 22'h25434),
                 mag_out, 22'h25431);

    apply_stimulus(20'h00000, 20'h10000);
    check_output("y_axis_angle", near(angle_out, HALF_PI, 4), angle_out, HALF_PI);

    apply_stimulus(20'hF0000, 20'h00000);
    check_output("neg_x_angle", near(angle_out, PI, 4), angle_out, PI);

    apply_stimulus(20'h00000, 20'hF0000);
    check_output("neg_y_angle", near(angle_out, 20'hC0000, 4), angle_out, 20'hC0000);

    apply_stimulus(20'h80000, 20'h80000);
    check_output("min_diag_angle", near(angle_out, 20'hA0000, 4), angle_out, 20'hA0000);
    check_output("min_diag_mag", (mag_out > 22'd1200000) && (mag_out < 22'd1240000),
                 mag_out, 22'd1221001);

    apply_stimulus(20'h00000, 20'h00000);
    check_output("origin_angle", angle_out === '0, angle_out, 0);
    check_output("origin_mag", mag_out === '0, mag_out, 0);

    apply_stimulus(20'h80000, 20'h00000);
    apply_stimulus(20'h7FFFF, 20'h80001);
    apply_stimulus(20'h23456, 20'hFC000);

    // Extra starts while busy must be dropped, not queued
    x_in  = 20'h20000;
    y_in  = 20'h10000;
    start = 1'b1;
    tick();
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      start = (k < 15) ? ~start : 1'b0;
      x_in  = 20'h0ABCD + 20'(k);
      y_in  = 20'hF1234;
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check_output("busy_start_latency", lat == ITERS + 2, lat, ITERS + 2);
    apply_stimulus(20'h10000, 20'h10000);
    check_output("restart_angle", near(angle_out, 20'h20000, 4), angle_out, 20'h20000);

    // Abort during iteration 8
    x_in  = 20'h30000;
    y_in  = 20'h18000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("abort_busy", busy === 1'b0, busy, 0);
    check_output("abort_angle", angle_out === '0, angle_out, 0);
    repeat (25) tick();
    check_output("abort_no_done", done === 1'b0, done, 0);

    apply_stimulus(20'h00000, 20'h10000);
    check_output("post_abort_angle", near(angle_out, HALF_PI, 4), angle_out, HALF_PI);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
